// File: rtl/fp_pkg.sv
// fp_pkg -- shared definitions for the floating-point adder issuer.
//   op_t       : request operation encodings (FAD, FSB, FLT, FLOOR)
//   state_t    : issuer state encoding (IDLE, RUN, DONE)
//   FLOOR_BIAS : 2^23 as an IEEE-754 single; adding it to a value in
//                FLOOR mode leaves the integer part in the low mantissa bits.
package fp_pkg;

    typedef enum logic [1:0] {
        OP_FAD   = 2'b00,
        OP_FSB   = 2'b01,
        OP_FLT   = 2'b10,
        OP_FLOOR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [31:0] FLOOR_BIAS = 32'h4B00_0000;

endpackage

// File: rtl/fp_issue_wdog.sv
// fp_issue_wdog -- stall watchdog for fp_add_issuer.
// Counts cycles in which the adder is running and stalled; flags expiry in
// the cycle that would make the count reach TIMEOUT.
// Ports:
//   clk      in  clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   clr      in  restart the count (new request accepted)
//   count_en in  adder running with fpa_stall high this cycle
//   expired  out combinational: this stall cycle is number TIMEOUT
module fp_issue_wdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic count_en,
    output logic expired
);

    // The counter only needs to hold 0..TIMEOUT-1; expiry fires on the
    // TIMEOUT-th stall cycle itself.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_reg;

    assign expired = count_en && (cnt_reg == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (count_en && !expired) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/fp_add_issuer.sv
// fp_add_issuer -- issues one floating-point operation at a time to a
// multi-cycle adder and returns its result through a valid/ready port.
// Optional feature: define FP_ISSUE_TIMEOUT_EN to abort an operation whose
// adder stalls for TIMEOUT running cycles (rsp_err=1, rsp_data=0).
// Ports:
//   clk, rst_n                 clock / asynchronous active-low reset
//   req_valid/req_ready        request handshake; req_op, req_a, req_b payload
//   fpa_run/fpa_u/fpa_v        adder run, FLT select, FLOOR select
//   fpa_en                     adder clock enable (high whenever out of reset)
//   fpa_x/fpa_y                adder operands, stable for the whole run
//   fpa_stall/fpa_z            adder busy flag and result
//   rsp_valid/rsp_ready        response handshake; rsp_data result, rsp_err abort
module fp_add_issuer
    import fp_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        fpa_run,
    output logic        fpa_u,
    output logic        fpa_v,
    output logic        fpa_en,
    output logic [31:0] fpa_x,
    output logic [31:0] fpa_y,
    input  logic        fpa_stall,
    input  logic [31:0] fpa_z,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    state_t      state_reg;
    logic        run_reg;
    logic        u_reg;
    logic        v_reg;
    logic        en_reg;
    logic [31:0] x_reg;
    logic [31:0] y_reg;
    logic [31:0] data_reg;
    logic        valid_reg;
    logic        err_reg;
    logic        accept;
    logic        timeout_hit;

    assign req_ready = (state_reg == ST_IDLE);
    assign accept    = req_valid && req_ready;

`ifdef FP_ISSUE_TIMEOUT_EN
    fp_issue_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept),
        .count_en ((state_reg == ST_RUN) && fpa_stall),
        .expired  (timeout_hit)
    );
`else
    // No watchdog: a stalled adder is waited on indefinitely.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            run_reg   <= 1'b0;
            u_reg     <= 1'b0;
            v_reg     <= 1'b0;
            en_reg    <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            en_reg <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        run_reg   <= 1'b1;
                        err_reg   <= 1'b0;
                        state_reg <= ST_RUN;
                        case (op_t'(req_op))
                            OP_FAD: begin
                                x_reg <= req_a;
                                y_reg <= req_b;
                                u_reg <= 1'b0;
                                v_reg <= 1'b0;
                            end
                            OP_FSB: begin
                                // Subtraction is addition of the sign-flipped operand.
                                x_reg <= req_a;
                                y_reg <= {~req_b[31], req_b[30:0]};
                                u_reg <= 1'b0;
                                v_reg <= 1'b0;
                            end
                            OP_FLT: begin
                                x_reg <= req_a;
                                y_reg <= '0;
                                u_reg <= 1'b1;
                                v_reg <= 1'b0;
                            end
                            OP_FLOOR: begin
                                x_reg <= FLOOR_BIAS;
                                y_reg <= req_a;
                                u_reg <= 1'b0;
                                v_reg <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    if (!fpa_stall) begin
                        data_reg  <= fpa_z;
                        valid_reg <= 1'b1;
                        run_reg   <= 1'b0;
                        state_reg <= ST_DONE;
                    end else if (timeout_hit) begin
                        data_reg  <= '0;
                        err_reg   <= 1'b1;
                        valid_reg <= 1'b1;
                        run_reg   <= 1'b0;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // fpa_run is already low here, so the adder's step
                    // counter is back at zero before the next issue.
                    if (rsp_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign fpa_run   = run_reg;
    assign fpa_u     = u_reg;
    assign fpa_v     = v_reg;
    assign fpa_en    = en_reg;
    assign fpa_x     = x_reg;
    assign fpa_y     = y_reg;
    assign rsp_valid = valid_reg;
    assign rsp_data  = data_reg;
`ifdef FP_ISSUE_TIMEOUT_EN
    assign rsp_err   = err_reg;
`else
    logic unused_err;
    assign unused_err = err_reg;
    assign rsp_err    = 1'b0;
`endif

endmodule
